cascade_controller: RTL
=======================

// Module: cascade_controller
// PURPOSE
//  Sequential cascade-bus controller for the PIC; replaces the combinational cascade buffer/comparator.
//  Master: drives the slave ID on CAS for the whole INTA sequence when the acknowledged IR input carries a slave.
//  Slave: latches CAS on the first INTA and flags a match against its own ICW3 ID.
//  Tracks INTA pulses for 8080 (3-pulse) and 8086 (2-pulse) modes; tells the data-bus stage which byte to drive.
// PARAMETERS
//  CAS_W        3    width of the cascade ID bus
//  NUM_IR       8    IR inputs per device; must equal 2**CAS_W
//  TIMEOUT_CYC  64   max clk cycles between INTA pulses (used only with CAS_TIMEOUT_EN)
// PORTS
//  clk            in   1         system clock; all state changes on its rising edge
//  rst_n          in   1         asynchronous, active-low reset
//  inta_n         in   1         INTA strobe, already synchronised to clk, active low
//  mode_8086      in   1         1 = 2-pulse sequence, 0 = 3-pulse (8080) sequence
//  sp_en_n        in   1         1 = master, 0 = slave (buffered SP/EN strap)
//  sngl           in   1         ICW1 SNGL; 1 = no cascading
//  icw3           in   NUM_IR    master: slave-present mask; slave: ID in [CAS_W-1:0]
//  ack_id         in   CAS_W     IR index granted by the priority resolver; valid at the first INTA fall
//  cas_in         in   CAS_W     sampled CAS pins
//  cas_out        out  CAS_W     value driven on the CAS pins
//  cas_oe         out  1         CAS pin output enable
//  slave_sel      out  1         slave: this device was addressed in the current sequence
//  own_vector     out  1         this device drives the vector byte(s) on D[7:0]
//  pulse_idx      out  2         current INTA pulse: 0 idle, 1..3
//  seq_done       out  1         1-cycle pulse on the rising inta_n that ends the sequence
//  seq_abort      out  1         1-cycle pulse on timeout (0 when CAS_TIMEOUT_EN is off)
// BEHAVIOUR
//  - Reset: every output is 0, FSM in IDLE, latched registers are 0.
//  - Edge detect: inta_q is inta_n delayed by one clk. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
//  - Last pulse index: 2 when mode_8086=1, else 3. mode_8086 is sampled at the first fall and held.
//  - FSM states: IDLE -> P1 -> P2 [-> P3] -> IDLE.
//    - Each fall advances the state one step and sets pulse_idx.
//    - The rise that ends the last pulse returns to IDLE, pulses seq_done, and clears cas_oe, slave_sel, own_vector.
//  - At the first fall (IDLE->P1):
//    - Always latch ack_id into id_q.
//    - Master, sngl=0, icw3[ack_id]=1: cas_out<=ack_id and cas_oe<=1 on that edge; own_vector<=0.
//    - Master, otherwise: cas_oe<=0, cas_out<=0, own_vector<=1.
//    - Slave: if sngl=0 and cas_in==icw3[CAS_W-1:0], then slave_sel<=1 and own_vector<=1; otherwise both stay 0.
//  - cas_out and cas_oe are stable from the first fall until the sequence ends. Latency: 1 clk after the fall.
//  - A fall in IDLE while inta_n is already low after reset is ignored; the first rise arms detection.
//  - sp_en_n and icw3 changing mid-sequence have no effect until the next IDLE->P1.
//  - A fall during P2 with mode_8086=1 cannot occur before the rise; extra falls beyond the last pulse are ignored until IDLE.
//  - Asserting rst_n low mid-sequence forces IDLE and all outputs to 0 immediately (asynchronous).
//  - A rise when the FSM is not on its last pulse only keeps the current state.
// CONFIGURATION
//  CAS_TIMEOUT_EN defined:
//    - A 7-bit-or-wider counter runs in any non-IDLE state and is cleared on each fall.
//    - When it reaches TIMEOUT_CYC, go to IDLE, clear all outputs, and pulse seq_abort for 1 clk.
//  CAS_TIMEOUT_EN undefined: no counter; seq_abort is tied to 0; a stalled sequence holds forever.
// TESTING
//  1. Master, 8086, sngl=0, icw3=8'h10, ack_id=4 -> cas_oe=1, cas_out=3'd4 from fall+1 to the 2nd rise; own_vector=0; seq_done once.
//  2. Master, 8080, icw3=8'h00, ack_id=2 -> cas_oe=0, own_vector=1, pulse_idx 1,2,3, then seq_done on the 3rd rise.
//  3. Slave, icw3[2:0]=3'd5, cas_in=5 at the 1st fall -> slave_sel=1 and own_vector=1; repeat with cas_in=6 -> both stay 0.
//  4. sngl=1 with master, icw3=8'hFF -> cas_oe never asserts; own_vector=1.
//  5. rst_n low during P2 -> all outputs 0 in the same cycle; the next sequence runs normally.
//  6. CAS_TIMEOUT_EN, TIMEOUT_CYC=64, one INTA then none -> seq_abort at 64 clks after the fall; cas_oe=0.

Source files
------------

// File: rtl/cascade_controller.sv
// Cascade-bus controller for the PIC: the master drives the slave ID on CAS, the slave matches CAS
// against its ICW3 ID, and both track the INTA pulse sequence. Optional macro: CAS_TIMEOUT_EN.
module cascade_controller #(
    parameter int CAS_W       = 3,
    parameter int NUM_IR      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inta_n,
    input  logic              mode_8086,
    input  logic              sp_en_n,
    input  logic              sngl,
    input  logic [NUM_IR-1:0] icw3,
    input  logic [CAS_W-1:0]  ack_id,
    input  logic [CAS_W-1:0]  cas_in,
    output logic [CAS_W-1:0]  cas_out,
    output logic              cas_oe,
    output logic              slave_sel,
    output logic              own_vector,
    output logic [1:0]        pulse_idx,
    output logic              seq_done,
    output logic              seq_abort
);

    if (NUM_IR != (1 << CAS_W)) begin : g_bad_num_ir
        $error("NUM_IR must equal 2**CAS_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

    state_t           state, state_d;
    logic             inta_q;
    logic             mode_q, mode_d;
    logic [CAS_W-1:0] id_q, id_d;
    logic             cas_oe_d, slave_sel_d, own_vector_d, seq_done_d, seq_abort_d;
    logic [1:0]       pulse_idx_d;
    logic             fall, rise, last;

    // inta_q resets low, so a strobe already low after reset cannot look like a fall until it has risen once.
    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;
    assign last = (state == P3) || ((state == P2) && mode_q);

    // The master drives the latched ID only while the bus is enabled.
    assign cas_out = cas_oe ? id_q : '0;

`ifdef CAS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 7) ? $clog2(TIMEOUT_CYC + 1) : 7;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state;
        mode_d       = mode_q;
        id_d         = id_q;
        cas_oe_d     = cas_oe;
        slave_sel_d  = slave_sel;
        own_vector_d = own_vector;
        pulse_idx_d  = pulse_idx;
        seq_done_d   = 1'b0;
        seq_abort_d  = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_d     = P1;
                    pulse_idx_d = 2'd1;
                    mode_d      = mode_8086;
                    id_d        = ack_id;
                    cas_oe_d    = 1'b0;
                    slave_sel_d = 1'b0;
                    if (sp_en_n) begin
                        if (!sngl && icw3[ack_id]) begin
                            cas_oe_d     = 1'b1;
                            own_vector_d = 1'b0;
                        end else begin
                            own_vector_d = 1'b1;
                        end
                    end else if (!sngl && (cas_in == icw3[CAS_W-1:0])) begin
                        slave_sel_d  = 1'b1;
                        own_vector_d = 1'b1;
                    end else begin
                        own_vector_d = 1'b0;
                    end
                end
            end
            P1: begin
                if (fall) begin
                    state_d     = P2;
                    pulse_idx_d = 2'd2;
                end
            end
            P2: begin
                if (fall && !mode_q) begin
                    state_d     = P3;
                    pulse_idx_d = 2'd3;
                end
            end
            default: ;
        endcase

        if (rise && last) begin
            state_d      = IDLE;
            pulse_idx_d  = 2'd0;
            cas_oe_d     = 1'b0;
            slave_sel_d  = 1'b0;
            own_vector_d = 1'b0;
            seq_done_d   = 1'b1;
        end

`ifdef CAS_TIMEOUT_EN
        cnt_d = '0;
        if (state != IDLE && !fall) begin
            cnt_d = cnt_q + 1'b1;
            // Stalled sequence: abandon it and release the bus.
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                cnt_d        = '0;
                state_d      = IDLE;
                pulse_idx_d  = 2'd0;
                cas_oe_d     = 1'b0;
                slave_sel_d  = 1'b0;
                own_vector_d = 1'b0;
                seq_done_d   = 1'b0;
                seq_abort_d  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inta_q     <= 1'b0;
            mode_q     <= 1'b0;
            id_q       <= '0;
            cas_oe     <= 1'b0;
            slave_sel  <= 1'b0;
            own_vector <= 1'b0;
            pulse_idx  <= 2'd0;
            seq_done   <= 1'b0;
            seq_abort  <= 1'b0;
        end else begin
            state      <= state_d;
            inta_q     <= inta_n;
            mode_q     <= mode_d;
            id_q       <= id_d;
            cas_oe     <= cas_oe_d;
            slave_sel  <= slave_sel_d;
            own_vector <= own_vector_d;
            pulse_idx  <= pulse_idx_d;
            seq_done   <= seq_done_d;
            seq_abort  <= seq_abort_d;
        end
    end

`ifdef CAS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule
